// File: rtl/toggle_hs_pkg.sv
// rtl/toggle_hs_pkg.sv - shared types and default widths for the toggle handshake
// Purpose: handshake FSM state type and default widths shared by sender and receiver.
// Ports: none (package).
package toggle_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // no word held; waiting for a request toggle
    HOLD = 1'b1   // word presented on the valid/ready port
  } hs_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/toggle_edge_detect.sv
// rtl/toggle_edge_detect.sv - request toggle event detector with load-enabled reference level
// Purpose: flags a request event while the incoming toggle level differs from the
//          last accepted level; the reference level only moves when load_i is set.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset (reference level returns to 0)
//   tgl_i   in   request toggle level from the sender
//   load_i  in   accept the current toggle level as the new reference
//   evt_o   out  toggle level differs from the accepted reference
module toggle_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  input  logic load_i,
  output logic evt_o
);

  logic req_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_prev_q <= 1'b0;
    end else if (load_i) begin
      req_prev_q <= tgl_i;
    end
  end

  // A level mismatch stays visible until the word is actually captured, so a
  // toggle that arrives while a word is still held is delivered later, not lost.
  assign evt_o = tgl_i ^ req_prev_q;

endmodule

// File: rtl/toggle_handshake_rx.sv
// rtl/toggle_handshake_rx.sv - two-phase toggle handshake receiver with valid/ready output
// Purpose: captures a word on each request toggle, presents it on a valid/ready
//          port and returns an acknowledge toggle once the consumer accepts it.
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   req_tgl     in   request toggle; each level change is one new word
//   req_data    in   word, stable until the matching ack toggle
//   ack_tgl     out  acknowledge toggle, flips once per consumed word
//   out_valid   out  captured word available
//   out_ready   in   consumer accepts when high together with out_valid
//   out_data    out  captured word
//   xfer_count  out  completed transfers, modulo 2^CNT_WIDTH
//   proto_err   out  sticky flag: request toggled again before acknowledge
module toggle_handshake_rx
  import toggle_hs_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_tgl,
  input  logic [WIDTH-1:0]     req_data,
  output logic                 ack_tgl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 proto_err
);

  hs_state_t            state_q, state_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 ack_q, ack_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 req_evt;
  logic                 load_prev;

  toggle_edge_detect u_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .tgl_i  (req_tgl),
    .load_i (load_prev),
    .evt_o  (req_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ack_d     = ack_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    load_prev = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_evt) begin
          data_d    = req_data;
          valid_d   = 1'b1;
          load_prev = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // A toggle here means the sender did not wait for the ack. It is left
        // pending in the edge detector and picked up once we are back in IDLE.
        if (req_evt) begin
          err_d = 1'b1;
        end
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_tgl    = ack_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign xfer_count = cnt_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// tb/tb_toggle_handshake_rx.sv - self-checking bench for toggle_handshake_rx
module tb_toggle_handshake_rx;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_tgl;
  logic [W-1:0]  req_data;
  logic          ack_tgl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] xfer_count;
  logic          proto_err;

  toggle_handshake_rx #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tgl    (req_tgl),
    .req_data   (req_data),
    .ack_tgl    (ack_tgl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model in transaction terms: words captured vs words accepted.
  int           n_cap;
  int           n_acc;
  bit           m_err;
  logic [W-1:0] m_last;
  logic         lvl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n_cap  = 0;
    n_acc  = 0;
    m_err  = 1'b0;
    m_last = '0;
  endtask

  task automatic check_all();
    bit holding;
    holding = (n_cap > n_acc);
    chk("out_valid",  32'(out_valid),  32'(holding));
    chk("ack_tgl",    32'(ack_tgl),    32'(n_acc % 2));
    chk("xfer_count", 32'(xfer_count), 32'(n_acc % (1 << CW)));
    chk("proto_err",  32'(proto_err),  32'(m_err));
    chk("out_data",   32'(out_data),   32'(m_last));
  endtask

  // Called at a negedge: drive inputs, advance the model over the next rising
  // edge, then check the outputs at the following negedge.
  task automatic cyc(input bit r, input bit t, input logic [W-1:0] d, input bit rdy);
    bit pending;
    rst       = r;
    req_tgl   = t;
    req_data  = d;
    out_ready = rdy;
    pending   = (t != bit'(n_cap % 2));
    if (r) begin
      model_reset();
    end else if (n_cap == n_acc) begin
      if (pending) begin
        n_cap++;
        m_last = d;
      end
    end else begin
      if (pending) m_err = 1'b1;
      if (rdy) n_acc++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst       = 1'b1;
    req_tgl   = 1'b0;
    req_data  = '0;
    out_ready = 1'b0;
    lvl       = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    chk("reset_count", 32'(xfer_count), 32'd0);

    // Single transfer, ready high.
    lvl = 1'b1;
    cyc(0, lvl, 8'hA5, 1);
    chk("a5_valid", 32'(out_valid), 32'd1);
    chk("a5_data",  32'(out_data),  32'hA5);
    cyc(0, lvl, 8'hA5, 1);
    chk("a5_ack",   32'(ack_tgl),    32'd1);
    chk("a5_count", 32'(xfer_count), 32'd1);

    // Back-pressure on 8'h3C.
    lvl = 1'b0;
    cyc(0, lvl, 8'h3C, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, lvl, 8'h3C, 0);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_ack",  32'(ack_tgl),  32'd1);
    end
    cyc(0, lvl, 8'h3C, 1);
    chk("bp_ack_flip", 32'(ack_tgl), 32'd0);

    // Five back-to-back transfers.
    for (int i = 1; i <= 5; i++) begin
      lvl = ~lvl;
      cyc(0, lvl, W'(i), 1);
      chk("b2b_data", 32'(out_data), 32'(i));
      cyc(0, lvl, W'(i), 1);
    end
    chk("b2b_ack", 32'(ack_tgl),   32'd1);
    chk("b2b_err", 32'(proto_err), 32'd0);

    // Violation: second toggle while holding 8'h77.
    lvl = ~lvl;
    cyc(0, lvl, 8'h77, 0);
    lvl = ~lvl;
    cyc(0, lvl, 8'h88, 0);
    chk("viol_err",  32'(proto_err), 32'd1);
    chk("viol_data", 32'(out_data),  32'h77);
    cyc(0, lvl, 8'h88, 1);
    cyc(0, lvl, 8'h88, 1);
    chk("late_data", 32'(out_data), 32'h88);
    cyc(0, lvl, 8'h88, 1);
    lvl = ~lvl;
    cyc(0, lvl, 8'h99, 1);
    cyc(0, lvl, 8'h99, 1);
    chk("err_sticky", 32'(proto_err), 32'd1);

    // Counter wrap, then reset while holding.
    lvl = 1'b0;
    cyc(1, lvl, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      lvl = ~lvl;
      cyc(0, lvl, W'(8'h40 + i), 1);
      cyc(0, lvl, W'(8'h40 + i), 1);
    end
    chk("wrap_count", 32'(xfer_count), 32'd1);
    lvl = ~lvl;
    cyc(0, lvl, 8'h5A, 0);
    lvl = 1'b0;
    cyc(1, lvl, 8'h5A, 0);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_ack",   32'(ack_tgl),    32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);

    // Randomized traffic, occasional violations and resets.
    for (int i = 0; i < 3000; i++) begin
      bit holding;
      bit rdy;
      bit r;
      holding = (n_cap > n_acc);
      rdy     = ($urandom_range(0, 3) != 0);
      r       = ($urandom_range(0, 299) == 0);
      if (r) begin
        lvl = 1'b0;
      end else if (!holding && (bit'(n_acc % 2) == lvl) && ($urandom_range(0, 2) != 0)) begin
        lvl      = ~lvl;
        req_data = W'($urandom);
      end else if (holding && ($urandom_range(0, 40) == 0)) begin
        lvl      = ~lvl;
        req_data = W'($urandom);
      end
      cyc(r, lvl, req_data, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
